ir_key_dec: RTL and testbench

- Downstream consumer of the IR receiver's 32-bit NEC frame.
- Validates address and command complements, suppresses auto-repeat duplicates, and maps remote keys to digit, clear and backspace actions.
- Keeps a six-digit BCD entry buffer that feeds the per-digit fnd_dec instances and led_disp in the top level.

---
 rtl/ir_key_dec_pkg.sv | 42 ++++
 rtl/ir_key_dec_if.sv | 23 ++
 rtl/ir_key_dec_ms_timer.sv | 59 +++++
 rtl/ir_key_dec.sv | 178 +++++++++++++++++
 tb/tb_ir_key_dec.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/ir_key_dec_pkg.sv
// Shared definitions for the NEC key decoder: FSM states, frame field
// positions, remote key codes and the frame complement test.
package ir_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      APPLY = 2'd2
   } state_t;

   localparam int ADDR_MSB  = 31;
   localparam int ADDR_LSB  = 24;
   localparam int NADDR_MSB = 23;
   localparam int NADDR_LSB = 16;
   localparam int CMD_MSB   = 15;
   localparam int CMD_LSB   = 8;
   localparam int NCMD_MSB  = 7;
   localparam int NCMD_LSB  = 0;

   localparam logic [7:0] KEY_0   = 8'h16;
   localparam logic [7:0] KEY_1   = 8'h0C;
   localparam logic [7:0] KEY_2   = 8'h18;
   localparam logic [7:0] KEY_3   = 8'h5E;
   localparam logic [7:0] KEY_4   = 8'h08;
   localparam logic [7:0] KEY_5   = 8'h1C;
   localparam logic [7:0] KEY_6   = 8'h5A;
   localparam logic [7:0] KEY_7   = 8'h42;
   localparam logic [7:0] KEY_8   = 8'h52;
   localparam logic [7:0] KEY_9   = 8'h4A;
   localparam logic [7:0] KEY_CLR = 8'h45;
   localparam logic [7:0] KEY_BS  = 8'h44;

   // Extended NEC remotes reuse the inverted-address byte, so its check is optional.
   function automatic logic cmpl_ok(input logic [31:0] frame, input logic chk_addr);
      logic cmd_ok;
      logic addr_ok;
      cmd_ok  = (frame[CMD_MSB:CMD_LSB] == ~frame[NCMD_MSB:NCMD_LSB]);
      addr_ok = (frame[ADDR_MSB:ADDR_LSB] == ~frame[NADDR_MSB:NADDR_LSB]);
      return cmd_ok && (addr_ok || !chk_addr);
   endfunction

endpackage

// File: rtl/ir_key_dec_if.sv
// Frame input and decoded key/status outputs of the IR key decoder.
interface ir_key_dec_if;
   logic [31:0] i_frame;
   logic        i_frame_vld;
   logic [7:0]  o_addr;
   logic [7:0]  o_cmd;
   logic        o_key_vld;
   logic        o_rpt;
   logic        o_err;
   logic        o_ovf;
   logic [23:0] o_digits;
   logic [2:0]  o_digit_cnt;

   modport master (
      output i_frame, i_frame_vld,
      input  o_addr, o_cmd, o_key_vld, o_rpt, o_err, o_ovf, o_digits, o_digit_cnt
   );

   modport slave (
      input  i_frame, i_frame_vld,
      output o_addr, o_cmd, o_key_vld, o_rpt, o_err, o_ovf, o_digits, o_digit_cnt
   );
endinterface

// File: rtl/ir_key_dec_ms_timer.sv
// Repeat-suppression hold timer: free-running 1 ms divider feeding a
// saturating millisecond counter that reads as expired at HOLD_MS.
module ms_timer #(
   parameter int CLK_HZ  = 50000000,
   parameter int HOLD_MS = 120
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_restart,
   output logic o_expired
);
   localparam int               DIV      = CLK_HZ / 1000;
   localparam int               DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [7:0]       HOLD     = 8'(HOLD_MS);

   logic [DIV_W-1:0] div_r;
   logic             tick_s;
   logic [7:0]       ms_r;
   logic [7:0]       ms_nxt_s;
   logic             expired_r;

   assign tick_s    = (div_r == DIV_LAST);
   assign o_expired = expired_r;

   // Divider never restarts, so the hold window jitters by under one ms.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_r <= {DIV_W{1'b0}};
      end else if (tick_s) begin
         div_r <= {DIV_W{1'b0}};
      end else begin
         div_r <= div_r + DIV_W'(1);
      end
   end

   // Next millisecond count: restart wins, otherwise count up and stick at HOLD.
   always_comb begin
      ms_nxt_s = ms_r;
      if (i_restart) begin
         ms_nxt_s = 8'd0;
      end else if (tick_s && (ms_r != HOLD)) begin
         ms_nxt_s = ms_r + 8'd1;
      end else begin
         ms_nxt_s = ms_r;
      end
   end

   // Counter and expired flag; out of reset the window is already closed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ms_r      <= HOLD;
         expired_r <= 1'b1;
      end else begin
         ms_r      <= ms_nxt_s;
         expired_r <= (ms_nxt_s == HOLD);
      end
   end
endmodule

// File: rtl/ir_key_dec.sv
// NEC frame validator with repeat suppression and a six-digit BCD entry
// buffer driven by digit, backspace and clear keys.
module ir_key_dec
   import ir_pkg::*;
#(
   parameter int CLK_HZ   = 50000000,
   parameter int HOLD_MS  = 120,
   parameter int CHK_ADDR = 1
) (
   input logic        clk,
   input logic        rst_n,
   ir_key_dec_if.slave bus
);
   state_t      state_r;
   state_t      state_nxt_s;
   logic [31:0] frame_r;
   logic [31:0] last_r;
   logic        pass_s;
   logic        expired_s;
   logic        restart_s;
   logic        err_nxt_s;
   logic        rpt_nxt_s;
   logic        apply_s;
   logic        digit_vld_s;
   logic [3:0]  digit_s;
   logic        is_bs_s;
   logic        is_clr_s;
   logic [7:0]  addr_r;
   logic [7:0]  cmd_r;
   logic        key_vld_r;
   logic        rpt_r;
   logic        err_r;
   logic        ovf_r;
   logic [23:0] digits_r;
   logic [2:0]  cnt_r;

   assign pass_s = cmpl_ok(frame_r, (CHK_ADDR != 0));

   ms_timer #(.CLK_HZ(CLK_HZ), .HOLD_MS(HOLD_MS)) u_ms_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_restart (restart_s),
      .o_expired (expired_s)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next state plus the decision strobes that feed the output registers.
   always_comb begin
      state_nxt_s = state_r;
      err_nxt_s   = 1'b0;
      rpt_nxt_s   = 1'b0;
      apply_s     = 1'b0;
      restart_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.i_frame_vld) begin
               state_nxt_s = CHECK;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         CHECK: begin
            if (!pass_s) begin
               err_nxt_s   = 1'b1;
               state_nxt_s = IDLE;
            end else if ((frame_r == last_r) && !expired_s) begin
               rpt_nxt_s   = 1'b1;
               restart_s   = 1'b1;
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = APPLY;
            end
         end
         APPLY: begin
            apply_s     = 1'b1;
            restart_s   = 1'b1;
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Remote key code to buffer action.
   always_comb begin
      digit_vld_s = 1'b1;
      digit_s     = 4'd0;
      is_bs_s     = 1'b0;
      is_clr_s    = 1'b0;
      case (frame_r[CMD_MSB:CMD_LSB])
         KEY_0:   digit_s = 4'd0;
         KEY_1:   digit_s = 4'd1;
         KEY_2:   digit_s = 4'd2;
         KEY_3:   digit_s = 4'd3;
         KEY_4:   digit_s = 4'd4;
         KEY_5:   digit_s = 4'd5;
         KEY_6:   digit_s = 4'd6;
         KEY_7:   digit_s = 4'd7;
         KEY_8:   digit_s = 4'd8;
         KEY_9:   digit_s = 4'd9;
         KEY_BS:  begin digit_vld_s = 1'b0; is_bs_s  = 1'b1; end
         KEY_CLR: begin digit_vld_s = 1'b0; is_clr_s = 1'b1; end
         default: digit_vld_s = 1'b0;
      endcase
   end

   // Frame capture; only IDLE accepts, so a busy strobe cannot disturb it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_r <= 32'd0;
      end else if ((state_r == IDLE) && bus.i_frame_vld) begin
         frame_r <= bus.i_frame;
      end else begin
         frame_r <= frame_r;
      end
   end

   // Pulse outputs and the accepted-frame registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_vld_r <= 1'b0;
         rpt_r     <= 1'b0;
         err_r     <= 1'b0;
         ovf_r     <= 1'b0;
         addr_r    <= 8'd0;
         cmd_r     <= 8'd0;
         last_r    <= 32'd0;
      end else begin
         key_vld_r <= apply_s;
         rpt_r     <= rpt_nxt_s;
         err_r     <= err_nxt_s;
         ovf_r     <= bus.i_frame_vld && (state_r != IDLE);
         if (apply_s) begin
            addr_r <= frame_r[ADDR_MSB:ADDR_LSB];
            cmd_r  <= frame_r[CMD_MSB:CMD_LSB];
            last_r <= frame_r;
         end
      end
   end

   // Digit entry buffer: shift left on digits, right on backspace.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digits_r <= 24'd0;
         cnt_r    <= 3'd0;
      end else if (apply_s && is_clr_s) begin
         digits_r <= 24'd0;
         cnt_r    <= 3'd0;
      end else if (apply_s && is_bs_s) begin
         digits_r <= {4'd0, digits_r[23:4]};
         cnt_r    <= (cnt_r == 3'd0) ? 3'd0 : cnt_r - 3'd1;
      end else if (apply_s && digit_vld_s) begin
         digits_r <= {digits_r[19:0], digit_s};
         cnt_r    <= (cnt_r == 3'd6) ? 3'd6 : cnt_r + 3'd1;
      end else begin
         digits_r <= digits_r;
         cnt_r    <= cnt_r;
      end
   end

   assign bus.o_addr      = addr_r;
   assign bus.o_cmd       = cmd_r;
   assign bus.o_key_vld   = key_vld_r;
   assign bus.o_rpt       = rpt_r;
   assign bus.o_err       = err_r;
   assign bus.o_ovf       = ovf_r;
   assign bus.o_digits    = digits_r;
   assign bus.o_digit_cnt = cnt_r;
endmodule

// File: tb/tb_ir_key_dec.sv
// Directed scoreboard bench for ir_key_dec with a fast clock divider (10 cycles per ms).
module tb_ir_key_dec;
   import ir_pkg::*;

   localparam int CLK_HZ = 10000;
   localparam int CYC_MS = CLK_HZ / 1000;
   localparam int K_KEY  = 0;
   localparam int K_RPT  = 1;
   localparam int K_ERR  = 2;

   typedef struct {
      int          kind;
      int          lat;
      logic [7:0]  addr;
      logic [7:0]  cmd;
      logic [23:0] digits;
      logic [2:0]  cnt;
   } exp_t;

   logic clk;
   logic rst_n;
   ir_key_dec_if bus ();

   exp_t        sb[$];
   int          n_checks;
   int          n_fail;
   logic [7:0]  m_addr;
   logic [7:0]  m_cmd;
   logic [23:0] m_digits;
   logic [2:0]  m_cnt;
   logic [7:0]  key_tab [10];

   ir_key_dec #(.CLK_HZ(CLK_HZ), .HOLD_MS(120), .CHK_ADDR(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [31:0] nec(input logic [7:0] addr, input logic [7:0] cmd);
      return {addr, ~addr, cmd, ~cmd};
   endfunction

   // Reference behaviour of an accepted key on the entry buffer.
   task automatic model_key(input logic [7:0] cmd);
      if (cmd == 8'h45) begin
         m_digits = 24'd0;
         m_cnt    = 3'd0;
      end else if (cmd == 8'h44) begin
         m_digits = m_digits >> 4;
         m_cnt    = (m_cnt == 3'd0) ? 3'd0 : m_cnt - 3'd1;
      end else begin
         for (int i = 0; i < 10; i++) begin
            if (key_tab[i] == cmd) begin
               m_digits = {m_digits[19:0], 4'(i)};
               m_cnt    = (m_cnt >= 3'd6) ? 3'd6 : m_cnt + 3'd1;
            end
         end
      end
   endtask

   task automatic push_exp(input logic [31:0] f, input int kind, input int lat);
      exp_t e;
      if (kind == K_KEY) begin
         m_addr = f[31:24];
         m_cmd  = f[15:8];
         model_key(f[15:8]);
      end
      e.kind   = kind;
      e.lat    = lat;
      e.addr   = m_addr;
      e.cmd    = m_cmd;
      e.digits = m_digits;
      e.cnt    = m_cnt;
      sb.push_back(e);
   endtask

   task automatic send(input logic [31:0] f);
      @(negedge clk);
      bus.i_frame     = f;
      bus.i_frame_vld = 1'b1;
      @(negedge clk);
      bus.i_frame_vld = 1'b0;
   endtask

   // Wait (bounded) for the next result pulse and compare it with the queue head.
   task automatic wait_evt(input string tag);
      exp_t e;
      int   got;
      int   lat;
      got = -1;
      lat = 0;
      while ((got < 0) && (lat < 8)) begin
         lat++;
         @(negedge clk);
         if (bus.o_key_vld)  got = K_KEY;
         else if (bus.o_rpt) got = K_RPT;
         else if (bus.o_err) got = K_ERR;
      end
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         chk({tag, "_kind"},   got,           e.kind);
         chk({tag, "_lat"},    lat,           e.lat);
         chk({tag, "_addr"},   bus.o_addr,    e.addr);
         chk({tag, "_cmd"},    bus.o_cmd,     e.cmd);
         chk({tag, "_digits"}, bus.o_digits,  e.digits);
         chk({tag, "_cnt"},    bus.o_digit_cnt, e.cnt);
      end
      @(negedge clk);
      chk({tag, "_pulse_end"}, {bus.o_key_vld, bus.o_rpt, bus.o_err, bus.o_ovf}, 32'd0);
   endtask

   task automatic press(input string tag, input logic [31:0] f, input int kind);
      send(f);
      push_exp(f, kind, (kind == K_KEY) ? 2 : 1);
      wait_evt(tag);
   endtask

   task automatic wait_ms(input int ms);
      repeat (ms * CYC_MS) @(negedge clk);
   endtask

   initial begin
      logic [7:0] seq [7];
      int         quiet;
      key_tab  = '{8'h16, 8'h0C, 8'h18, 8'h5E, 8'h08, 8'h1C, 8'h5A, 8'h42, 8'h52, 8'h4A};
      seq      = '{KEY_1, KEY_2, KEY_3, KEY_4, KEY_5, KEY_6, KEY_7};
      n_checks = 0;
      n_fail   = 0;
      m_addr   = 8'd0;
      m_cmd    = 8'd0;
      m_digits = 24'd0;
      m_cnt    = 3'd0;
      bus.i_frame     = 32'd0;
      bus.i_frame_vld = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_outputs", {bus.o_addr, bus.o_cmd, bus.o_key_vld, bus.o_rpt, bus.o_err, bus.o_ovf}, 32'd0);
      chk("rst_digits", {5'd0, bus.o_digit_cnt, bus.o_digits}, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_rst_digits", bus.o_digits, 32'd0);

      press("first_key1", 32'h00FF0CF3, K_KEY);
      chk("first_digits", bus.o_digits, 32'h000001);

      for (int i = 0; i < 7; i++) begin
         wait_ms(130);
         press("seq_key", nec(8'h00, seq[i]), K_KEY);
      end
      chk("full_digits", bus.o_digits, 32'h234567);
      chk("full_cnt", bus.o_digit_cnt, 32'd6);

      // Hold window: repeats restart it, so a held key keeps being suppressed.
      wait_ms(130);
      press("k5_new", nec(8'h00, KEY_5), K_KEY);
      wait_ms(60);
      press("k5_rpt60", nec(8'h00, KEY_5), K_RPT);
      wait_ms(200);
      press("k5_after200", nec(8'h00, KEY_5), K_KEY);
      wait_ms(100);
      press("k5_rpt100a", nec(8'h00, KEY_5), K_RPT);
      wait_ms(100);
      press("k5_rpt100b", nec(8'h00, KEY_5), K_RPT);

      press("bad_ncmd", 32'h00FF0C00, K_ERR);
      press("bad_naddr", 32'h01FF0CF3, K_ERR);
      press("k5_after_err", nec(8'h00, KEY_5), K_RPT);
      press("other_cmd", nec(8'h10, 8'h40), K_KEY);

      press("clr1", nec(8'h00, KEY_CLR), K_KEY);
      press("d1", nec(8'h00, KEY_1), K_KEY);
      press("d2", nec(8'h00, KEY_2), K_KEY);
      press("d3", nec(8'h00, KEY_3), K_KEY);
      chk("buf_123", bus.o_digits, 32'h000123);
      press("bs", nec(8'h00, KEY_BS), K_KEY);
      chk("buf_12", bus.o_digits, 32'h000012);
      chk("cnt_2", bus.o_digit_cnt, 32'd2);
      press("clr2", nec(8'h00, KEY_CLR), K_KEY);
      press("bs_empty", nec(8'h00, KEY_BS), K_KEY);
      chk("cnt_0", bus.o_digit_cnt, 32'd0);

      // Back-to-back strobes: the second is dropped with an overflow pulse.
      @(negedge clk);
      bus.i_frame     = nec(8'h00, KEY_9);
      bus.i_frame_vld = 1'b1;
      @(negedge clk);
      bus.i_frame     = nec(8'h00, KEY_8);
      @(negedge clk);
      bus.i_frame_vld = 1'b0;
      chk("ovf_pulse", bus.o_ovf, 32'd1);
      push_exp(nec(8'h00, KEY_9), K_KEY, 1);
      wait_evt("ovf_first");
      quiet = 0;
      repeat (6) begin
         @(negedge clk);
         quiet = quiet | {bus.o_key_vld, bus.o_rpt, bus.o_err};
      end
      chk("ovf_dropped", quiet, 32'd0);
      chk("ovf_digits", bus.o_digits, 32'h000009);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
